uart_frame_check: RTL
=====================

# uart_frame_check

Parametrised UART receive-frame deserialiser and checker, the next generation of the single-bit stop checker. Consumes one sampled bit per `bit_valid` strobe from the RX oversampling sampler, assembles the data word LSB first, and checks the parity bit and one or two stop bits. Publishes the word with parity, stop and break flags as a single-cycle `frm_done` event to the RX controller, and optionally keeps saturating error counters.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, legal range 5..9.
- `CNT_WIDTH`, 8: width of each error counter.

- `CLK` in 1: clock.
- `RST` in 1: synchronous reset, active-high.
- `frm_start` in 1: single-cycle pulse marking the accepted start bit. Latches the config inputs.
- `bit_valid` in 1: single-cycle strobe; `sampled_bit` holds the next frame bit.
- `sampled_bit` in 1: majority-voted bit value.
- `par_en` in 1: 1 means a parity bit follows the data.
- `par_typ` in 1: 0 selects even parity, 1 selects odd.
- `two_stop` in 1: 1 means two stop bits are checked.
- `clr_cnt` in 1: synchronous clear of both error counters.
- `p_data` out DATA_WIDTH: received word, LSB = first data bit.
- `frm_done` out 1: single-cycle frame-complete pulse.
- `par_err` out 1: parity mismatch in the last frame.
- `stp_err` out 1: at least one stop bit sampled 0 in the last frame.
- `brk_det` out 1: break detected. All data bits 0 and `stp_err` set.
- `par_err_cnt` out CNT_WIDTH: saturating parity-error count.
- `stp_err_cnt` out CNT_WIDTH: saturating stop-error count.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE to DATA on `frm_start`. At that edge, latch `par_en`, `par_typ` and `two_stop`, clear the bit counter and the running parity.
- DATA: each `bit_valid` shifts `sampled_bit` in LSB-first and XORs it into the running parity. After DATA_WIDTH bits, go to PARITY if latched `par_en`, else STOP1.
- PARITY: on `bit_valid`, the expected bit is running parity XOR latched `par_typ`; a mismatch records parity error. Go to STOP1.
- STOP1: on `bit_valid`, a 0 records stop error. Go to STOP2 if latched `two_stop`, else complete.
- STOP2: on `bit_valid`, a 0 also records stop error (the flag is the OR of both stop bits). Complete.
- Complete: return to IDLE. Register `p_data`, `par_err` (0 when parity disabled), `stp_err` and `brk_det`, and pulse `frm_done`.
- `bit_valid` in IDLE is ignored.
- `frm_start` outside IDLE aborts the current frame and restarts DATA. No `frm_done` is issued, and outputs keep their previous frame values.
- `frm_start` together with `bit_valid`: `frm_start` wins and the strobe is ignored (it is the start bit).
- Config inputs changing mid-frame have no effect; only the values latched at `frm_start` are used.

## Timing
- Reset: FSM to IDLE; `p_data`, `frm_done`, `par_err`, `stp_err`, `brk_det` and both counters go to 0.
- Reset mid-frame discards the partial frame; no `frm_done`.
- `frm_done` is high exactly one cycle, the cycle after the `bit_valid` of the last stop bit.
- `p_data`, `par_err`, `stp_err` and `brk_det` are valid from that cycle and held until the next `frm_done` or reset.
- Frame length in strobes: DATA_WIDTH + `par_en` + 1 + `two_stop`.
- The back-to-back case, `frm_start` in the same cycle as `frm_done`, is legal and starts the next frame.

## Configuration
- `FRAME_ERR_CNT_EN` defined:
  - Each counter increments by 1 in the `frm_done` cycle when its flag is set, saturating at 2^CNT_WIDTH-1.
  - `clr_cnt` zeroes both counters and wins over a simultaneous increment.
- Not defined: counter logic is omitted; `par_err_cnt` and `stp_err_cnt` are constant 0 and `clr_cnt` is ignored.

## Test plan
- DATA_WIDTH=8, even parity, one stop bit. Bits 0xA5 LSB-first, parity 0, stop 1 -> `frm_done` one cycle after the 10th strobe, `p_data`=0xA5, `par_err`=0, `stp_err`=0.
- Odd parity, data 0x03, parity bit 0 -> `par_err`=1. With `FRAME_ERR_CNT_EN`: `par_err_cnt` goes 0 to 1.
- `two_stop`=1, no parity, data 0x5A, stop bits 1 then 0 -> `stp_err`=1, `brk_det`=0, `frm_done` after the 10th strobe.
- All-zero data, stop 0 -> `brk_det`=1, `stp_err`=1.
- `frm_start` after 4 data bits, then a full 0x3C frame -> exactly one `frm_done`, `p_data`=0x3C.
- CNT_WIDTH=2 with `FRAME_ERR_CNT_EN`, five stop-error frames -> `stp_err_cnt` holds at 3. `clr_cnt` asserted in a `frm_done` cycle -> count 0.

Source files
------------

// File: rtl/uart_frame_check.sv
// UART receive-frame deserialiser: assembles LSB-first data, checks parity and stop bits, flags breaks.
// Optional saturating error counters are enabled by defining FRAME_ERR_CNT_EN.
module uart_frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  frm_start,
   input  logic                  bit_valid,
   input  logic                  sampled_bit,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic                  two_stop,
   input  logic                  clr_cnt,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  frm_done,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  brk_det,
   output logic [CNT_WIDTH-1:0]  par_err_cnt,
   output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

   localparam int BW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  run_par_q, run_par_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  two_stop_q, two_stop_d;
   logic                  par_bad_q, par_bad_d;
   logic                  stp_bad_q, stp_bad_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  frm_done_q, frm_done_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;
   logic                  brk_det_q, brk_det_d;
   logic                  complete;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      run_par_d  = run_par_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      two_stop_d = two_stop_q;
      par_bad_d  = par_bad_q;
      stp_bad_d  = stp_bad_q;
      complete   = 1'b0;

      // A start pulse restarts the frame from any state and swallows a coincident strobe.
      if (frm_start) begin
         state_d    = DATA;
         bit_cnt_d  = '0;
         run_par_d  = 1'b0;
         par_bad_d  = 1'b0;
         stp_bad_d  = 1'b0;
         par_en_d   = par_en;
         par_typ_d  = par_typ;
         two_stop_d = two_stop;
      end else if (bit_valid) begin
         unique case (state_q)
            DATA: begin
               shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
               run_par_d = run_par_q ^ sampled_bit;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? PARITY : STOP1;
               end
            end
            PARITY: begin
               if (sampled_bit != (run_par_q ^ par_typ_q)) begin
                  par_bad_d = 1'b1;
               end
               state_d = STOP1;
            end
            STOP1: begin
               if (!sampled_bit) begin
                  stp_bad_d = 1'b1;
               end
               if (two_stop_q) begin
                  state_d = STOP2;
               end else begin
                  state_d  = IDLE;
                  complete = 1'b1;
               end
            end
            STOP2: begin
               if (!sampled_bit) begin
                  stp_bad_d = 1'b1;
               end
               state_d  = IDLE;
               complete = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      p_data_d   = p_data_q;
      par_err_d  = par_err_q;
      stp_err_d  = stp_err_q;
      brk_det_d  = brk_det_q;
      frm_done_d = complete;
      if (complete) begin
         p_data_d  = shift_q;
         par_err_d = par_bad_q;
         stp_err_d = stp_bad_d;
         brk_det_d = (shift_q == '0) && stp_bad_d;
      end
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (RST) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         run_par_q  <= 1'b0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         two_stop_q <= 1'b0;
         par_bad_q  <= 1'b0;
         stp_bad_q  <= 1'b0;
         p_data_q   <= '0;
         frm_done_q <= 1'b0;
         par_err_q  <= 1'b0;
         stp_err_q  <= 1'b0;
         brk_det_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         run_par_q  <= run_par_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         two_stop_q <= two_stop_d;
         par_bad_q  <= par_bad_d;
         stp_bad_q  <= stp_bad_d;
         p_data_q   <= p_data_d;
         frm_done_q <= frm_done_d;
         par_err_q  <= par_err_d;
         stp_err_q  <= stp_err_d;
         brk_det_q  <= brk_det_d;
      end
   end

   assign p_data   = p_data_q;
   assign frm_done = frm_done_q;
   assign par_err  = par_err_q;
   assign stp_err  = stp_err_q;
   assign brk_det  = brk_det_q;

`ifdef FRAME_ERR_CNT_EN
   logic [CNT_WIDTH-1:0] par_err_cnt_q, par_err_cnt_d;
   logic [CNT_WIDTH-1:0] stp_err_cnt_q, stp_err_cnt_d;

   // Counters advance on the published flags; a clear in the same cycle wins.
   always_comb begin
      par_err_cnt_d = par_err_cnt_q;
      stp_err_cnt_d = stp_err_cnt_q;
      if (clr_cnt) begin
         par_err_cnt_d = '0;
         stp_err_cnt_d = '0;
      end else if (frm_done_q) begin
         if (par_err_q && (par_err_cnt_q != '1)) par_err_cnt_d = par_err_cnt_q + 1'b1;
         if (stp_err_q && (stp_err_cnt_q != '1)) stp_err_cnt_d = stp_err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         par_err_cnt_q <= '0;
         stp_err_cnt_q <= '0;
      end else begin
         par_err_cnt_q <= par_err_cnt_d;
         stp_err_cnt_q <= stp_err_cnt_d;
      end
   end

   assign par_err_cnt = par_err_cnt_q;
   assign stp_err_cnt = stp_err_cnt_q;
`else
   logic unused_clr_cnt;
   assign unused_clr_cnt = clr_cnt;
   assign par_err_cnt    = '0;
   assign stp_err_cnt    = '0;
`endif

endmodule
